fifo_push_arbiter: RTL and testbench

- Shares one simple_fifo write port between N requesters using round-robin arbitration.
- Requesters may lock the grant for bounded bursts.
- Tracks FIFO occupancy with an internal credit counter, so writes are never issued into a full FIFO even though its push/data inputs are driven from registers.
- Sits between producer blocks and the simple_fifo push/in_data/full side.

---
 rtl/fifo_push_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//
// Shares a single simple_fifo write port between N producers. Normal operation
// is round-robin; a producer that holds lock when it wins keeps the grant for up
// to MAX_BURST consecutive beats. An internal credit counter tracks entries that
// are either stored in the FIFO or still sitting in the registered push stage.
// No grant is issued unless a credit is free, so the FIFO never sees a push
// while it is full.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   req        per-requester write request (data valid while high)
//   lock       per-requester burst hold (only meaningful together with req)
//   req_data   packed data, requester i at [i*W +: W]
//   gnt        one-hot combinational grant; data is taken at the edge it is high
//   fifo_push  registered push to the FIFO
//   fifo_data  registered data to the FIFO
//   fifo_pop   consumer pop to the FIFO (observed only)
//   fifo_empty FIFO empty flag
//   credits    entries committed (in flight or stored)
//   busy       high while a locked burst owns the port
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req,
  input  logic [N-1:0]               lock,
  input  logic [N*W-1:0]             req_data,
  output logic [N-1:0]               gnt,
  output logic                       fifo_push,
  output logic [W-1:0]               fifo_data,
  input  logic                       fifo_pop,
  input  logic                       fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [BW-1:0] MAX_C    = BW'(MAX_BURST);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr, rr_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [CW-1:0] credits_nxt;

  logic          avail;
  logic          accept;
  logic          pop_vld;
  logic          idle_hit;
  logic [PW-1:0] idle_win;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] win;

  // Increment a requester index modulo N (N need not be a power of two).
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign avail = (credits < DEPTH_C);

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    idle_hit = 1'b0;
    idle_win = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (!idle_hit && req[scan_idx]) begin
        idle_hit = 1'b1;
        idle_win = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // During a burst only the owner can be granted; everyone else waits even
  // when the owner itself is stalled on credits.
  always_comb begin
    gnt = '0;
    if (rst && avail) begin
      if (state == IDLE) begin
        if (idle_hit) gnt[idle_win] = 1'b1;
      end else if (req[owner]) begin
        gnt[owner] = 1'b1;
      end
    end
  end

  assign win    = (state == IDLE) ? idle_win : owner;
  assign accept = |gnt;
  assign busy   = (state == BURST);

  // A pop on an empty FIFO does nothing; the credits guard keeps the counter
  // from wrapping if the consumer misbehaves.
  assign pop_vld = fifo_pop & ~fifo_empty & (credits != '0);

  always_comb begin
    credits_nxt = credits;
    if (accept && !pop_vld) begin
      credits_nxt = credits + 1'b1;
    end else if (!accept && pop_vld) begin
      credits_nxt = credits - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (accept) begin
          if (lock[win] && (MAX_BURST > 1)) begin
            state_nxt = BURST;
            owner_nxt = win;
            beat_nxt  = BW'(1);
          end else begin
            rr_nxt = wrap_inc(win);
          end
        end
      end
      BURST: begin
        // Owner dropping req ends the burst immediately, without a beat.
        if (!req[owner]) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
          rr_nxt    = wrap_inc(owner);
        end else if (accept) begin
          if (lock[owner] && ((beat_cnt + 1'b1) < MAX_C)) begin
            beat_nxt = beat_cnt + 1'b1;
          end else begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            rr_nxt    = wrap_inc(owner);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      credits  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
      rr_ptr   <= rr_nxt;
      credits  <= credits_nxt;
    end
  end

  // Push stage: one cycle from grant to FIFO write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_push <= 1'b0;
      fifo_data <= '0;
    end else begin
      fifo_push <= accept;
      if (accept) fifo_data <= req_data[win*W +: W];
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Random traffic against a behavioural model of the arbiter plus a queue model
// of the downstream FIFO. Granted data is queued as it is granted; a separate
// monitor pops and compares whenever the DUT pushes.
// -----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

  localparam int N         = 4;
  localparam int W         = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_BURST = 4;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int NCYC      = 6000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_push;
  logic [W-1:0]   fifo_data;
  logic           fifo_pop;
  logic           fifo_empty;
  logic [CW-1:0]  credits;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];   // scoreboard: data expected on upcoming pushes
  logic [W-1:0] fq[$];      // contents of the modelled downstream FIFO

  // Reference state: owner -1 means no burst in progress.
  int           m_owner;
  int           m_beats;
  int           m_rr;
  int           m_cred;
  logic         m_push;
  logic [W-1:0] m_data;

  always #5 clk = ~clk;

  fifo_push_arbiter #(
    .N         (N),
    .W         (W),
    .DEPTH     (DEPTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_push  (fifo_push),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .fifo_empty (fifo_empty),
    .credits    (credits),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every DUT push must match the oldest outstanding grant.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (fifo_push === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("push_unexpected", 64'(fifo_data), 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("push_data", 64'(fifo_data), 64'(e));
        end
      end
    end
  end

  initial begin
    int           p_req;
    int           p_lock;
    int           p_pop;
    int           win;
    int           idx;
    logic [N-1:0] eg;
    logic         popv;

    rst        = 1'b0;
    req        = '1;
    lock       = '0;
    req_data   = '0;
    fifo_pop   = 1'b0;
    fifo_empty = 1'b1;
    m_owner    = -1;
    m_beats    = 0;
    m_rr       = 0;
    m_cred     = 0;
    m_push     = 1'b0;
    m_data     = '0;
    p_req      = 80;
    p_lock     = 10;
    p_pop      = 60;

    @(posedge clk); #1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc % 250 == 0) begin
        case ($urandom_range(0, 3))
          0:       begin p_req = 80; p_lock = 10; p_pop = 60; end
          1:       begin p_req = 90; p_lock = 0;  p_pop = 5;  end
          2:       begin p_req = 85; p_lock = 75; p_pop = 70; end
          default: begin p_req = 40; p_lock = 40; p_pop = 40; end
        endcase
      end

      rst = (cyc < 2) ? 1'b0 : ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        req[i]             = (cyc < 2) ? 1'b1 : ($urandom_range(0, 99) < p_req);
        lock[i]            = ($urandom_range(0, 99) < p_lock);
        req_data[i*W +: W] = $urandom;
      end
      fifo_pop   = ($urandom_range(0, 99) < p_pop);
      fifo_empty = (fq.size() == 0);

      @(negedge clk);

      // Expected grant for this cycle.
      win = -1;
      if (rst) begin
        if (m_cred < DEPTH) begin
          if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
              idx = (m_rr + k) % N;
              if (win < 0 && req[idx]) win = idx;
            end
          end else if (req[m_owner]) begin
            win = m_owner;
          end
        end
      end
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;

      chk("gnt",       64'(gnt),       64'(eg));
      chk("busy",      64'(busy),      64'(m_owner >= 0));
      chk("credits",   64'(credits),   64'(m_cred));
      chk("fifo_push", 64'(fifo_push), 64'(m_push));
      chk("fifo_data", 64'(fifo_data), 64'(m_data));

      // Advance model across the coming edge.
      popv = fifo_pop && !fifo_empty;
      if (!rst) begin
        m_owner = -1;
        m_beats = 0;
        m_rr    = 0;
        m_cred  = 0;
        m_push  = 1'b0;
        m_data  = '0;
        fq.delete();
      end else begin
        if (popv) void'(fq.pop_front());
        if (fifo_push) fq.push_back(fifo_data);

        m_cred = m_cred + ((win >= 0) ? 1 : 0) - (popv ? 1 : 0);
        m_push = (win >= 0);
        if (win >= 0) begin
          m_data = req_data[win*W +: W];
          exp_q.push_back(req_data[win*W +: W]);
        end

        if (m_owner < 0) begin
          if (win >= 0) begin
            if (lock[win] && MAX_BURST > 1) begin
              m_owner = win;
              m_beats = 1;
            end else begin
              m_rr = (win + 1) % N;
            end
          end
        end else if (!req[m_owner]) begin
          m_rr    = (m_owner + 1) % N;
          m_owner = -1;
          m_beats = 0;
        end else if (win >= 0) begin
          m_beats = m_beats + 1;
          if (!lock[m_owner] || m_beats >= MAX_BURST) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
            m_beats = 0;
          end
        end
      end

      @(posedge clk); #1;
    end

    // Let the last granted beat reach the push register and the monitor.
    req  = '0;
    lock = '0;
    rst  = 1'b1;
    @(negedge clk); #1;
    chk("drain", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
